// File: rtl/multibyte_add_sequencer_if.sv
// multibyte_add_sequencer_if
//   Request/result bundle between a requester and the multi-byte add sequencer.
//   Parameter BYTES sets the operand width (8*BYTES bits).
//   Optional macro ADD_SUB_EN adds the 'sub' request signal.
//   Signals:
//     start     requester -> sequencer  operation request
//     a, b      requester -> sequencer  operands
//     c_in      requester -> sequencer  initial carry-in
//     sub       requester -> sequencer  subtract select (ADD_SUB_EN only)
//     busy      sequencer -> requester  operation in progress
//     done      sequencer -> requester  one-cycle result-valid pulse
//     sum       sequencer -> requester  held result
//     carry_out sequencer -> requester  carry out of the top byte
//   Modports: master (requester side), slave (sequencer side).
interface multibyte_add_sequencer_if #(
  parameter int BYTES = 4
);
  logic                 start;
  logic [8*BYTES-1:0]   a;
  logic [8*BYTES-1:0]   b;
  logic                 c_in;
`ifdef ADD_SUB_EN
  logic                 sub;
`endif
  logic                 busy;
  logic                 done;
  logic [8*BYTES-1:0]   sum;
  logic                 carry_out;

`ifdef ADD_SUB_EN
  modport master (output start, a, b, c_in, sub, input busy, done, sum, carry_out);
  modport slave  (input start, a, b, c_in, sub, output busy, done, sum, carry_out);
`else
  modport master (output start, a, b, c_in, input busy, done, sum, carry_out);
  modport slave  (input start, a, b, c_in, output busy, done, sum, carry_out);
`endif
endinterface

// File: rtl/multibyte_add_sequencer.sv
// multibyte_add_sequencer
//   Performs an 8*BYTES-bit addition by reusing one eight_bit_adder, one byte
//   per clock, least-significant byte first, with the carry chained through a
//   register. Start/busy/done handshake; result held until the next done.
//   Optional macro ADD_SUB_EN: adds a 'sub' request; when set, computes a - b
//   (B bytes inverted, initial carry forced to 1, c_in ignored) and carry_out=1
//   means no borrow.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  synchronous active-low reset
//     bus    multibyte_add_sequencer_if.slave (start/a/b/c_in[/sub] in,
//            busy/done/sum/carry_out out)
//   Parameter BYTES: operand width in bytes, 1..16.

// Plain 8-bit ripple adder; the shared datapath the sequencer time-multiplexes.
module eight_bit_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_in,
  output logic [7:0] sum,
  output logic       carry
);
  assign {carry, sum} = {1'b0, a} + {1'b0, b} + {8'h00, c_in};
endmodule

module multibyte_add_sequencer #(
  parameter int BYTES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  multibyte_add_sequencer_if.slave   bus
);
  // A one-byte operand still needs a 1-bit index register.
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int W     = 8 * BYTES;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state_r;
  logic [W-1:0]      a_r;
  logic [W-1:0]      b_r;
  logic [W-1:0]      acc_r;
  logic [IDX_W-1:0]  idx_r;
  logic              carry_r;
  logic              busy_r;
  logic              done_r;
  logic [W-1:0]      sum_r;
  logic              carry_out_r;
`ifdef ADD_SUB_EN
  logic              sub_r;
`endif

  logic [IDX_W+2:0]  off_s;
  logic [7:0]        a_byte_s;
  logic [7:0]        b_byte_s;
  logic [7:0]        adder_sum_s;
  logic              adder_carry_s;
  logic [W-1:0]      acc_next_s;

  // Bit offset of the byte being processed this cycle.
  assign off_s    = {idx_r, 3'b000};
  assign a_byte_s = a_r[off_s +: 8];

  // Select the B byte, inverted in subtract mode so a + ~b + 1 = a - b.
  always_comb begin
    b_byte_s = b_r[off_s +: 8];
`ifdef ADD_SUB_EN
    if (sub_r) begin
      b_byte_s = ~b_r[off_s +: 8];
    end else begin
      b_byte_s = b_r[off_s +: 8];
    end
`endif
  end

  eight_bit_adder u_adder (
    .a     (a_byte_s),
    .b     (b_byte_s),
    .c_in  (carry_r),
    .sum   (adder_sum_s),
    .carry (adder_carry_s)
  );

  // Accumulator with the current byte slot replaced by the adder result, so
  // the final edge can publish the complete sum in the same cycle.
  always_comb begin
    acc_next_s              = acc_r;
    acc_next_s[off_s +: 8]  = adder_sum_s;
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      a_r         <= '0;
      b_r         <= '0;
      acc_r       <= '0;
      idx_r       <= '0;
      carry_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      sum_r       <= '0;
      carry_out_r <= 1'b0;
`ifdef ADD_SUB_EN
      sub_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_r     <= bus.a;
            b_r     <= bus.b;
            idx_r   <= '0;
`ifdef ADD_SUB_EN
            sub_r   <= bus.sub;
            carry_r <= bus.sub ? 1'b1 : bus.c_in;
`else
            carry_r <= bus.c_in;
`endif
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          acc_r   <= acc_next_s;
          carry_r <= adder_carry_s;
          if (idx_r == LAST_IDX) begin
            // Last byte: publish result; start is not looked at this edge.
            sum_r       <= acc_next_s;
            carry_out_r <= adder_carry_s;
            done_r      <= 1'b1;
            busy_r      <= 1'b0;
            idx_r       <= '0;
            state_r     <= ST_IDLE;
          end else begin
            idx_r   <= idx_r + IDX_W'(1);
            done_r  <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.sum       = sum_r;
  assign bus.carry_out = carry_out_r;
endmodule
